mips_multiciclo_core: RTL

//  Self-contained multicycle MIPS-subset core: control FSM, register file, ALU and PC in one block.

---
 rtl/mips_multiciclo_core.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multiciclo_core.sv
// Multicycle MIPS-subset core: control FSM, register file, ALU and PC behind one
// unified req/ready memory port with wait-state support and illegal-opcode trapping.
module mips_multiciclo_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_out,
    output logic [3:0]  state_out,
    output logic        err
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic        err_q, err_d;
    logic [31:0] regs_q [1:NREGS-1];

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] immSext;
    logic [31:0] rsVal, rtVal;
    logic        regWe;
    logic [4:0]  regWaddr;
    logic [31:0] regWdata;
    logic        reqRaw, weRaw;
    logic [31:0] addrRaw;

    assign op      = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign funct   = ir_q[5:0];
    assign immSext = {{16{ir_q[15]}}, ir_q[15:0]};

    // $0 and unimplemented indices fall through the mux and read as zero
    always_comb begin
        rsVal = '0;
        rtVal = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs == 5'(i)) rsVal = regs_q[i];
            if (rt == 5'(i)) rtVal = regs_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        err_d    = err_q;
        regWe    = 1'b0;
        regWaddr = rt;
        regWdata = alu_q;
        reqRaw   = 1'b0;
        weRaw    = 1'b0;
        addrRaw  = pc_q;
        mem_wdata = b_q;
        case (state_q)
            S_FETCH: begin
                reqRaw = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rsVal;
                b_d   = rtVal;
                alu_d = pc_q + (immSext << 2);
                case (op)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC: begin
                state_d = S_ALUWB;
                case (funct)
                    6'h20:   alu_d = a_q + b_q;
                    6'h22:   alu_d = a_q - b_q;
                    6'h24:   alu_d = a_q & b_q;
                    6'h25:   alu_d = a_q | b_q;
                    6'h2A:   alu_d = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_ALUWB: begin
                regWe    = 1'b1;
                regWaddr = rd;
                state_d  = S_FETCH;
            end
            S_MEMADR: begin
                alu_d   = a_q + immSext;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                reqRaw  = 1'b1;
                addrRaw = alu_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regWe    = 1'b1;
                regWdata = mdr_q;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                reqRaw  = 1'b1;
                weRaw   = 1'b1;
                addrRaw = alu_q;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                if (((op == OP_BEQ) && (a_q == b_q)) || ((op == OP_BNE) && (a_q != b_q)))
                    pc_d = alu_q;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alu_d   = a_q + immSext;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regWe   = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                state_d = S_ILLEGAL;
            end
            default: state_d = S_FETCH;
        endcase
        // err rises together with the entry into the trap state
        if (state_d == S_ILLEGAL) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            if (reset)
                regs_q[i] <= '0;
            else if (regWe && (regWaddr == 5'(i)))
                regs_q[i] <= regWdata;
        end
    end

    // A request is never presented while reset is held, so an aborted access ends at once
    assign mem_req   = reqRaw & ~reset;
    assign mem_we    = weRaw & reqRaw & ~reset;
    assign mem_addr  = {addrRaw[31:2], 2'b00};
    assign pc_out    = pc_q;
    assign state_out = state_q;
    assign err       = err_q;

endmodule
